// File: rtl/mul_issue.sv
// Issue/sequencing stage in front of the multi-cycle integer multiplier core.
// Captures a request, starts the core, waits for done (or times out) and buffers the response.
`timescale 1ns/1ps
module mul_issue #(
  parameter int TIMEOUT = 40,
  parameter int TW      = 6
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rd,
  input  logic        i_flush,
  output logic        o_mul_valid,
  output logic [31:0] o_mul_a,
  output logic [31:0] o_mul_b,
  input  logic        i_mul_valid,
  input  logic [31:0] i_mul_result,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_err,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   res_q;
  logic [4:0]    rd_q;
  logic          err_q;
  logic [TW-1:0] timer;
  logic          accept;
  logic          zero_op;
  logic          tmo;

  assign accept  = i_valid & (state == S_IDLE) & ~i_flush;
  assign zero_op = (i_rs1 == 32'd0) | (i_rs2 == 32'd0);
  assign tmo     = (timer == TMAX);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = zero_op ? S_RESP : S_START;
      S_START: state_nxt = i_flush ? S_DRAIN : S_WAIT;
      // Flush overrides done and timeout; the core still has to be drained.
      S_WAIT: begin
        if (i_flush)                state_nxt = S_DRAIN;
        else if (i_mul_valid | tmo) state_nxt = S_RESP;
      end
      S_DRAIN: if (i_mul_valid | tmo) state_nxt = S_IDLE;
      S_RESP:  if (i_flush | i_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready     = (state == S_IDLE);
    o_busy      = (state != S_IDLE);
    o_mul_valid = (state == S_START);
    o_valid     = (state == S_RESP);
  end

  assign o_mul_a  = a_q;
  assign o_mul_b  = b_q;
  assign o_result = res_q;
  assign o_rd     = rd_q;
  assign o_err    = err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      rd_q  <= 5'd0;
      res_q <= 32'd0;
      err_q <= 1'b0;
      timer <= '0;
    end else begin
      if (accept) begin
        a_q  <= i_rs1;
        b_q  <= i_rs2;
        rd_q <= i_rd;
        if (zero_op) begin
          res_q <= 32'd0;
          err_q <= 1'b0;
        end
      end
      case (state)
        S_START: timer <= '0;
        S_WAIT, S_DRAIN: timer <= timer + 1'b1;
        default: timer <= timer;
      endcase
      // Done wins over timeout when both land in the same cycle.
      if (state == S_WAIT && !i_flush) begin
        if (i_mul_valid) begin
          res_q <= i_mul_result;
          err_q <= 1'b0;
        end else if (tmo) begin
          res_q <= 32'd0;
          err_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue: latency, bypass, backpressure, flush, timeout, async reset.
`timescale 1ns/1ps
module tb_mul_issue;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_rs1;
  logic [31:0] i_rs2;
  logic [4:0]  i_rd;
  logic        i_flush;
  logic        o_mul_valid;
  logic [31:0] o_mul_a;
  logic [31:0] o_mul_b;
  logic        i_mul_valid;
  logic [31:0] i_mul_result;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic [4:0]  o_rd;
  logic        o_err;
  logic        o_busy;

  int n_assert = 0;
  int n_fail   = 0;
  int pulses   = 0;
  int vhits    = 0;
  int bad      = 0;

  mul_issue #(.TIMEOUT(40), .TW(6)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_rd         (i_rd),
    .i_flush      (i_flush),
    .o_mul_valid  (o_mul_valid),
    .o_mul_a      (o_mul_a),
    .o_mul_b      (o_mul_b),
    .i_mul_valid  (i_mul_valid),
    .i_mul_result (i_mul_result),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_result     (o_result),
    .o_rd         (o_rd),
    .o_err        (o_err),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n cycles, sampling on the falling edge.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge i_clk);
      if (o_mul_valid) pulses++;
      if (o_valid) vhits++;
    end
  endtask

  // Present a request for one cycle; returns in cycle 1 (the START cycle).
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    i_valid = 1'b1;
    i_rs1   = a;
    i_rs2   = b;
    i_rd    = rd;
    step(1);
    i_valid = 1'b0;
  endtask

  task automatic core_done(input logic [31:0] r);
    i_mul_valid  = 1'b1;
    i_mul_result = r;
    step(1);
    i_mul_valid  = 1'b0;
  endtask

  task automatic retire();
    i_ready = 1'b1;
    step(1);
    i_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_valid = 1'b0; i_rs1 = '0; i_rs2 = '0; i_rd = '0;
    i_flush = 1'b0; i_mul_valid = 1'b0; i_mul_result = '0; i_ready = 1'b0;
    repeat (2) @(negedge i_clk);
    check("rst_ready",  32'(o_ready), 1);
    check("rst_busy",   32'(o_busy), 0);
    check("rst_valid",  32'(o_valid), 0);
    check("rst_mulv",   32'(o_mul_valid), 0);
    check("rst_err",    32'(o_err), 0);
    check("rst_result", o_result, 0);
    check("rst_mul_a",  o_mul_a, 0);
    check("rst_rd",     32'(o_rd), 0);
    i_rst_n = 1'b1;
    step(1);

    // Basic: 7*6 with core latency 33
    pulses = 0;
    issue(32'd7, 32'd6, 5'd5);
    check("basic_start", 32'(o_mul_valid), 1);
    check("basic_mul_a", o_mul_a, 7);
    check("basic_mul_b", o_mul_b, 6);
    check("basic_notready", 32'(o_ready), 0);
    step(33);
    check("basic_early_valid", 32'(o_valid), 0);
    core_done(32'd42);
    check("basic_pulses", 32'(pulses), 1);
    check("basic_valid",  32'(o_valid), 1);
    check("basic_result", o_result, 42);
    check("basic_rd",     32'(o_rd), 5);
    check("basic_err",    32'(o_err), 0);
    retire();
    check("basic_ready_back", 32'(o_ready), 1);
    check("basic_valid_drop", 32'(o_valid), 0);

    // Zero-operand bypass
    pulses = 0;
    issue(32'd0, 32'h1234, 5'd3);
    check("zero_valid",  32'(o_valid), 1);
    check("zero_result", o_result, 0);
    check("zero_err",    32'(o_err), 0);
    check("zero_rd",     32'(o_rd), 3);
    check("zero_nostart", 32'(pulses), 0);
    retire();
    check("zero_ready_back", 32'(o_ready), 1);

    // Backpressure, with a stray done during RESP
    issue(32'd3, 32'd5, 5'd9);
    step(33);
    core_done(32'hDEADBEEF);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (o_valid !== 1'b1 || o_result !== 32'hDEADBEEF || o_rd !== 5'd9 || o_ready !== 1'b0) bad++;
      i_mul_valid  = (k == 2);
      i_mul_result = 32'h5555_5555;
      step(1);
    end
    i_mul_valid = 1'b0;
    check("bp_stable_cycles", 32'(bad), 0);
    check("bp_result_after", o_result, 32'hDEADBEEF);
    retire();
    check("bp_ready_back", 32'(o_ready), 1);

    // Flush while waiting on the core
    vhits = 0;
    issue(32'd11, 32'd13, 5'd7);
    step(5);
    i_flush = 1'b1;
    step(1);
    i_flush = 1'b0;
    check("flush_busy",   32'(o_busy), 1);
    check("flush_hold_a", o_mul_a, 11);
    step(27);
    check("flush_busy_pre_done", 32'(o_busy), 1);
    core_done(32'd77);
    check("flush_idle_after_done", 32'(o_busy), 0);
    check("flush_ready", 32'(o_ready), 1);
    check("flush_no_valid", 32'(vhits), 0);
    issue(32'd100, 32'd3, 5'd2);
    step(33);
    core_done(32'd300);
    check("post_flush_valid",  32'(o_valid), 1);
    check("post_flush_result", o_result, 300);
    check("post_flush_rd",     32'(o_rd), 2);
    retire();

    // Flush blocks acceptance in IDLE
    i_valid = 1'b1; i_flush = 1'b1; i_rs1 = 32'd1; i_rs2 = 32'd1;
    step(1);
    i_valid = 1'b0; i_flush = 1'b0;
    check("idle_flush_noaccept", 32'(o_busy), 0);

    // Timeout: core never answers
    issue(32'd5, 32'd5, 5'd1);
    step(40);
    check("tmo_not_yet", 32'(o_valid), 0);
    step(1);
    check("tmo_valid",  32'(o_valid), 1);
    check("tmo_err",    32'(o_err), 1);
    check("tmo_result", o_result, 0);
    core_done(32'd25);
    step(1);
    check("tmo_late_valid",  32'(o_valid), 1);
    check("tmo_late_result", o_result, 0);
    check("tmo_late_err",    32'(o_err), 1);
    retire();
    check("tmo_ready_back", 32'(o_ready), 1);

    // Asynchronous reset mid-WAIT, between clock edges
    issue(32'd9, 32'd9, 5'd4);
    step(8);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_ready", 32'(o_ready), 1);
    check("arst_busy",  32'(o_busy), 0);
    check("arst_mul_a", o_mul_a, 0);
    check("arst_mul_b", o_mul_b, 0);
    check("arst_rd",    32'(o_rd), 0);
    check("arst_err",   32'(o_err), 0);
    check("arst_valid", 32'(o_valid), 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    step(1);
    check("arst_release_ready", 32'(o_ready), 1);
    check("arst_release_busy",  32'(o_busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
